// File: rtl/nes_controller_port.sv
// nes_controller_port: NES $4016/$4017 controller port.
// A strobe write latches the pads; on the strobe fall a capture FSM clocks
// eight bits out of each pad into a snapshot that CPU reads then shift out.
// Optional feature macro: NES_CONTROLLER_PORT_CONTROLLER2_EN builds pad 2
// (pad2Clock, pad2Data and the $4017 read path).
`timescale 1ns/1ps
module nes_controller_port #(
  parameter int unsigned CLK_DIV  = 4,
  parameter logic [7:0]  OPEN_BUS = 8'h40
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cpuRW,
  input  logic       controller1Enable,
  input  logic       controller2Enable,
  input  logic [7:0] cpuData,
  output logic [7:0] controller1Data,
  output logic [7:0] controller2Data,
  output logic       padLatch,
  output logic       pad1Clock,
  input  logic       pad1Data
`ifdef NES_CONTROLLER_PORT_CONTROLLER2_EN
  ,
  output logic       pad2Clock,
  input  logic       pad2Data
`endif
);

`ifdef NES_CONTROLLER_PORT_CONTROLLER2_EN
  localparam int NPORTS = 2;
`else
  localparam int NPORTS = 1;
`endif

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, LATCH, SAMPLE, CLOCK} captureStateT;

  logic              strobeReg;
  logic              strobeNext;
  logic              strobeWrite;
  logic              strobeRise;
  logic              strobeFall;
  captureStateT      stateReg;
  captureStateT      stateNext;
  logic [7:0]        divReg;
  logic [7:0]        divNext;
  logic [2:0]        bitIdxReg;
  logic [2:0]        bitIdxNext;
  logic              divLast;
  logic              busy;
  logic              capLoad;
  logic              captureDone;
  logic              padLatchReg;
  logic              padClockReg;
  logic [NPORTS-1:0] padDataVec;
  logic [NPORTS-1:0] enableVec;
  logic [7:0]        portData [NPORTS];
  logic              unusedCpuData;

  // Only bit 0 of a $4016 write is meaningful.
  assign unusedCpuData = ^cpuData[7:1];

  assign padDataVec[0] = pad1Data;
  assign enableVec[0]  = controller1Enable;
`ifdef NES_CONTROLLER_PORT_CONTROLLER2_EN
  assign padDataVec[1] = pad2Data;
  assign enableVec[1]  = controller2Enable;
`endif

  // Strobe edges are taken against the value being written this cycle so the
  // FSM reacts on the same edge the strobe register changes.
  assign strobeWrite = ~controller1Enable & ~cpuRW;
  assign strobeNext  = strobeWrite ? cpuData[0] : strobeReg;
  assign strobeRise  = ~strobeReg & strobeNext;
  assign strobeFall  = strobeReg & ~strobeNext;
  assign busy        = (stateReg != IDLE);
  assign divLast     = (divReg == DIV_LAST);

  // Strobe register, written by $4016 stores.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) strobeReg <= 1'b0;
    else          strobeReg <= strobeNext;
  end

  // Capture FSM state, divider and bit index registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stateReg  <= IDLE;
      divReg    <= 8'd0;
      bitIdxReg <= 3'd0;
    end else begin
      stateReg  <= stateNext;
      divReg    <= divNext;
      bitIdxReg <= bitIdxNext;
    end
  end

  // Capture FSM next state: latch, then alternate sample-low / clock-high.
  always_comb begin
    stateNext   = stateReg;
    divNext     = divReg;
    bitIdxNext  = bitIdxReg;
    capLoad     = 1'b0;
    captureDone = 1'b0;
    case (stateReg)
      IDLE: begin
        divNext    = 8'd0;
        bitIdxNext = 3'd0;
        if (strobeFall) stateNext = LATCH;
      end
      LATCH: begin
        if (divLast) begin
          stateNext = SAMPLE;
          divNext   = 8'd0;
        end else begin
          divNext = divReg + 8'd1;
        end
      end
      SAMPLE: begin
        if (divLast) begin
          capLoad = 1'b1;
          divNext = 8'd0;
          if (bitIdxReg == 3'd7) begin
            stateNext   = IDLE;
            captureDone = 1'b1;
            bitIdxNext  = 3'd0;
          end else begin
            stateNext = CLOCK;
          end
        end else begin
          divNext = divReg + 8'd1;
        end
      end
      CLOCK: begin
        if (divLast) begin
          stateNext  = SAMPLE;
          bitIdxNext = bitIdxReg + 3'd1;
          divNext    = 8'd0;
        end else begin
          divNext = divReg + 8'd1;
        end
      end
      default: stateNext = IDLE;
    endcase
    // Re-raising the strobe mid-capture throws the capture away.
    if (busy && strobeRise) begin
      stateNext   = IDLE;
      divNext     = 8'd0;
      bitIdxNext  = 3'd0;
      capLoad     = 1'b0;
      captureDone = 1'b0;
    end
  end

  // Pad-facing lines are registered from the next state to keep them glitch-free.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      padLatchReg <= 1'b0;
      padClockReg <= 1'b0;
    end else begin
      padLatchReg <= strobeNext | (stateNext == LATCH);
      padClockReg <= (stateNext == CLOCK);
    end
  end

  assign padLatch  = padLatchReg;
  assign pad1Clock = padClockReg;
`ifdef NES_CONTROLLER_PORT_CONTROLLER2_EN
  assign pad2Clock = padClockReg;
`endif

  // Per-pad capture shift-in, snapshot and CPU read pointer.
  for (genvar gi = 0; gi < NPORTS; gi++) begin : portGen
    logic [7:0] capReg;
    logic [7:0] capNext;
    logic [7:0] readReg;
    logic [3:0] readIdxReg;
    logic       enableDlyReg;
    logic       readPendingReg;
    logic       readAccess;
    logic       enableRise;
    logic       advance;
    logic       readBit;

    assign readAccess = ~enableVec[gi] & cpuRW;
    assign enableRise = enableVec[gi] & ~enableDlyReg;
    assign advance    = enableRise & readPendingReg & ~strobeReg & ~busy & ~readIdxReg[3];

    // Capture bit insertion for the sample currently completing.
    always_comb begin
      capNext = capReg;
      if (capLoad) capNext[bitIdxReg] = ~padDataVec[gi];
    end

    // Capture buffer, snapshot, read pointer and access tracking.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        capReg         <= 8'd0;
        readReg        <= 8'd0;
        readIdxReg     <= 4'd8;
        enableDlyReg   <= 1'b1;
        readPendingReg <= 1'b0;
      end else begin
        capReg       <= capNext;
        enableDlyReg <= enableVec[gi];
        if (enableRise)      readPendingReg <= 1'b0;
        else if (readAccess) readPendingReg <= 1'b1;
        if (captureDone) begin
          readReg    <= capNext;
          readIdxReg <= 4'd0;
        end else if (advance) begin
          readIdxReg <= readIdxReg + 4'd1;
        end
      end
    end

    // Read bit: live pad while strobing, else snapshot bit, then ones.
    always_comb begin
      readBit = 1'b1;
      if (strobeReg)          readBit = ~padDataVec[gi];
      else if (!readIdxReg[3]) readBit = readReg[readIdxReg[2:0]];
    end

    assign portData[gi] = readAccess ? {OPEN_BUS[7:1], readBit} : 8'h00;
  end

  assign controller1Data = portData[0];
`ifdef NES_CONTROLLER_PORT_CONTROLLER2_EN
  assign controller2Data = portData[1];
`else
  assign controller2Data = (~controller2Enable & cpuRW) ? {OPEN_BUS[7:1], 1'b0} : 8'h00;
`endif

endmodule

// File: tb/tb_nes_controller_port.sv
// tb_nes_controller_port: directed vector table, hand-written corner sequences
// and randomized captures checked against a queue-based pad/read model.
`timescale 1ns/1ps
module tb_nes_controller_port;
  localparam int unsigned CLK_DIV  = 2;
  localparam logic [7:0]  OPEN_BUS = 8'h40;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       cpuRW;
  logic       controller1Enable;
  logic       controller2Enable;
  logic [7:0] cpuData;
  logic [7:0] controller1Data;
  logic [7:0] controller2Data;
  logic       padLatch;
  logic       pad1Clock;
  logic       pad1Data;
`ifdef NES_CONTROLLER_PORT_CONTROLLER2_EN
  logic       pad2Clock;
  logic       pad2Data;
`endif

  nes_controller_port #(.CLK_DIV(CLK_DIV), .OPEN_BUS(OPEN_BUS)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .cpuRW(cpuRW),
    .controller1Enable(controller1Enable),
    .controller2Enable(controller2Enable),
    .cpuData(cpuData),
    .controller1Data(controller1Data),
    .controller2Data(controller2Data),
    .padLatch(padLatch),
    .pad1Clock(pad1Clock),
    .pad1Data(pad1Data)
`ifdef NES_CONTROLLER_PORT_CONTROLLER2_EN
    ,
    .pad2Clock(pad2Clock),
    .pad2Data(pad2Data)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural pad: 4021-style shift register, loads while latched,
  // shifts on the rising edge of its clock, line level is active-low.
  logic [7:0] pad1Pattern = 8'hFF;
  logic [7:0] pad1Shift;
  logic       pad1ClockPrev;
  logic       directMode = 1'b0;
  logic       directVal = 1'b1;
  always @(posedge clk) begin
    pad1ClockPrev <= pad1Clock;
    if (padLatch) pad1Shift <= pad1Pattern;
    else if (pad1Clock && !pad1ClockPrev) pad1Shift <= {1'b1, pad1Shift[7:1]};
  end
  assign pad1Data = directMode ? directVal : pad1Shift[0];

`ifdef NES_CONTROLLER_PORT_CONTROLLER2_EN
  logic [7:0] pad2Pattern = 8'hFF;
  logic [7:0] pad2Shift;
  logic       pad2ClockPrev;
  always @(posedge clk) begin
    pad2ClockPrev <= pad2Clock;
    if (padLatch) pad2Shift <= pad2Pattern;
    else if (pad2Clock && !pad2ClockPrev) pad2Shift <= {1'b1, pad2Shift[7:1]};
  end
  assign pad2Data = pad2Shift[0];
`endif

  int checks = 0;
  int failures = 0;

  // Reference read queues: bits a port will return, in order, after a capture.
  bit q1[$];
  bit q2[$];

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %02h required %02h", name, got, exp);
    end else begin
      $display("ok   %s: got %02h", name, got);
    end
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic writeStrobe(input logic v);
    controller1Enable = 1'b0;
    cpuRW = 1'b0;
    cpuData = {7'($urandom), v};
    @(posedge clk);
    #1;
    controller1Enable = 1'b1;
    cpuRW = 1'b1;
    cpuData = 8'h00;
  endtask

  task automatic readPort(input int port, output logic [7:0] data);
    cpuRW = 1'b1;
    if (port == 1) controller1Enable = 1'b0;
    else           controller2Enable = 1'b0;
    @(negedge clk);
    data = (port == 1) ? controller1Data : controller2Data;
    @(posedge clk);
    #1;
    controller1Enable = 1'b1;
    controller2Enable = 1'b1;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] expectRead(inout bit q[$]);
    bit b;
    b = (q.size() > 0) ? q.pop_front() : 1'b1;
    return {OPEN_BUS[7:1], b};
  endfunction

  task automatic capture(input logic [7:0] pattern);
    pad1Pattern = pattern;
    writeStrobe(1'b1);
    writeStrobe(1'b0);
    idleCycles(40);
    q1.delete();
    for (int k = 0; k < 8; k++) q1.push_back(~pattern[k]);
`ifdef NES_CONTROLLER_PORT_CONTROLLER2_EN
    q2.delete();
    for (int k = 0; k < 8; k++) q2.push_back(~pad2Pattern[k]);
`endif
  endtask

  typedef struct {
    logic [7:0]  pattern;
    logic [71:0] expected;  // first read in the top byte
    string       name;
  } vecT;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecT         vecs[5];
    logic [7:0]  d;
    logic [7:0]  e;
    int          highCount;

    vecs[0] = '{8'hF6, 72'h41_40_40_41_40_40_40_40_41, "a_start"};
    vecs[1] = '{8'h00, 72'h41_41_41_41_41_41_41_41_41, "all_pressed"};
    vecs[2] = '{8'hFF, 72'h40_40_40_40_40_40_40_40_41, "none_pressed"};
    vecs[3] = '{8'h7F, 72'h40_40_40_40_40_40_40_41_41, "right_only"};
    vecs[4] = '{8'hAA, 72'h41_40_41_40_41_40_41_40_41, "alternate"};

    reset_n = 1'b0;
    cpuRW = 1'b1;
    controller1Enable = 1'b1;
    controller2Enable = 1'b1;
    cpuData = 8'h00;

    // Reset state.
    #12;
    check("reset_padLatch", {7'd0, padLatch}, 8'h00);
    check("reset_pad1Clock", {7'd0, pad1Clock}, 8'h00);
    check("reset_idle_data1", controller1Data, 8'h00);
    controller1Enable = 1'b0;
    #1;
    check("reset_selected_read", controller1Data, 8'h41);
    controller1Enable = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    idleCycles(2);
    readPort(1, d);
    check("post_reset_read", d, 8'h41);
    readPort(2, d);
`ifdef NES_CONTROLLER_PORT_CONTROLLER2_EN
    check("post_reset_read4017", d, 8'h41);
`else
    check("read4017_open_bus", d, 8'h40);
`endif
    check("idle_data2", controller2Data, 8'h00);

    // Directed table: capture each pattern and read nine times.
    for (int v = 0; v < 5; v++) begin
      capture(vecs[v].pattern);
      for (int k = 0; k < 9; k++) begin
        readPort(1, d);
        e = vecs[v].expected[8*(8-k) +: 8];
        check($sformatf("vec_%s_read%0d", vecs[v].name, k), d, e);
      end
    end

    // Live pad reads while strobing; then busy reads show the old snapshot.
    capture(8'hFE);  // snapshot bit0 = 1, bit1 = 0; pointer at 0
    directMode = 1'b1;
    writeStrobe(1'b1);
    for (int k = 0; k < 5; k++) begin
      directVal = k[0];
      readPort(1, d);
      check($sformatf("strobe_live_read%0d", k), d, {OPEN_BUS[7:1], ~directVal});
    end
    directMode = 1'b0;
    pad1Pattern = 8'hFF;
    writeStrobe(1'b0);
    idleCycles(2);
    readPort(1, d);
    check("busy_read_clk3", d, 8'h41);
    readPort(1, d);
    check("busy_read_again", d, 8'h41);
    idleCycles(40);
    readPort(1, d);
    check("after_busy_capture", d, 8'h40);

    // Abort mid-capture: FSM idles, latch high, clock stays low, snapshot kept.
    capture(8'hFB);
    readPort(1, d);
    check("abort_pre_read0", d, 8'h40);
    readPort(1, d);
    check("abort_pre_read1", d, 8'h40);
    writeStrobe(1'b1);
    writeStrobe(1'b0);
    idleCycles(8);
    writeStrobe(1'b1);
    check("abort_padLatch", {7'd0, padLatch}, 8'h01);
    highCount = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (pad1Clock || !padLatch) highCount++;
    end
    check("abort_clock_quiet", 8'(highCount), 8'h00);
    pad1Pattern = 8'hFF;
    writeStrobe(1'b0);
    idleCycles(2);
    readPort(1, d);
    check("abort_kept_snapshot", d, 8'h41);
    idleCycles(40);
    readPort(1, d);
    check("abort_next_capture", d, 8'h40);

    // Reset pulsed mid-capture: outputs clear at once, capture discarded.
    pad1Pattern = 8'h00;
    writeStrobe(1'b1);
    writeStrobe(1'b0);
    idleCycles(10);
    reset_n = 1'b0;
    #1;
    check("midreset_padLatch", {7'd0, padLatch}, 8'h00);
    check("midreset_pad1Clock", {7'd0, pad1Clock}, 8'h00);
    check("midreset_idle_data", controller1Data, 8'h00);
    controller1Enable = 1'b0;
    #1;
    check("midreset_selected", controller1Data, 8'h41);
    controller1Enable = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    highCount = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (pad1Clock || padLatch) highCount++;
    end
    check("midreset_fsm_waits", 8'(highCount), 8'h00);
    #1;
    readPort(1, d);
    check("midreset_read", d, 8'h41);
    readPort(1, d);
    check("midreset_read_sat", d, 8'h41);

`ifdef NES_CONTROLLER_PORT_CONTROLLER2_EN
    // Pad 2 holds B only; $4016 reads are independent.
    pad2Pattern = 8'hFD;
    capture(8'hF6);
    for (int k = 0; k < 8; k++) begin
      readPort(2, d);
      check($sformatf("pad2_b_read%0d", k), d, expectRead(q2));
    end
    for (int k = 0; k < 9; k++) begin
      readPort(1, d);
      check($sformatf("pad1_with_pad2_read%0d", k), d, expectRead(q1));
    end
`endif

    // Randomized captures and interleaved reads against the queue model.
    for (int it = 0; it < 12; it++) begin
      int nReads;
`ifdef NES_CONTROLLER_PORT_CONTROLLER2_EN
      pad2Pattern = 8'($urandom);
`endif
      capture(8'($urandom));
      nReads = $urandom_range(0, 10);
      for (int k = 0; k < nReads; k++) begin
        if ($urandom_range(0, 3) == 0) begin
          readPort(2, d);
`ifdef NES_CONTROLLER_PORT_CONTROLLER2_EN
          check($sformatf("rand%0d_4017_read%0d", it, k), d, expectRead(q2));
`else
          check($sformatf("rand%0d_4017_read%0d", it, k), d, {OPEN_BUS[7:1], 1'b0});
`endif
        end else begin
          readPort(1, d);
          check($sformatf("rand%0d_4016_read%0d", it, k), d, expectRead(q1));
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
